// File: rtl/axis_frame_source_if.sv
// Command and AXI4-Stream signal bundle for axis_frame_source.
// master = generator side (takes commands, drives the stream); slave = the peer side.
interface axis_frame_source_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   logic [15:0]           cmd_len;
   logic [7:0]            cmd_seed;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [DEST_WIDTH-1:0] cmd_dest;
   logic [USER_WIDTH-1:0] cmd_user;
   logic                  cmd_valid;
   logic                  cmd_ready;

   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic [KEEP_WIDTH-1:0] m_axis_tkeep;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;
   logic [ID_WIDTH-1:0]   m_axis_tid;
   logic [DEST_WIDTH-1:0] m_axis_tdest;
   logic [USER_WIDTH-1:0] m_axis_tuser;

   modport master (
      input  cmd_len, cmd_seed, cmd_id, cmd_dest, cmd_user, cmd_valid,
      output cmd_ready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      output m_axis_tid, m_axis_tdest, m_axis_tuser,
      input  m_axis_tready
   );

   modport slave (
      output cmd_len, cmd_seed, cmd_id, cmd_dest, cmd_user, cmd_valid,
      input  cmd_ready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tid, m_axis_tdest, m_axis_tuser,
      output m_axis_tready
   );
endinterface

// File: rtl/axis_frame_source.sv
// AXI4-Stream frame generator: one command beat in, one frame of incrementing
// bytes (seed, seed+1, ...) out, with per-frame tid/tdest/tuser.
module axis_frame_source #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   axis_frame_source_if.master   bus,
   output logic                  busy,
   output logic                  err_len,
   output logic [31:0]           frame_count
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   localparam int MAX_BEATS = (65535 + KEEP_WIDTH - 1) / KEEP_WIDTH;
   localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;
   localparam logic [7:0]  KEEP_STEP = 8'(KEEP_WIDTH);
   localparam logic [16:0] KEEP_W17  = 17'(KEEP_WIDTH);
   localparam logic [16:0] KEEP_M1   = 17'(KEEP_WIDTH - 1);

   logic [0:0]            r_state;
   logic [DATA_WIDTH-1:0] r_tdata;
   logic [KEEP_WIDTH-1:0] r_tkeep;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic [ID_WIDTH-1:0]   r_tid;
   logic [DEST_WIDTH-1:0] r_tdest;
   logic [USER_WIDTH-1:0] r_tuser;
   logic                  r_err_len;
   logic [31:0]           r_frame_count;
   logic [BEAT_W-1:0]     r_beats_left;   // beats still to load after the one on the bus
   logic [7:0]            r_next_base;    // byte value of lane 0 in the next beat
   logic [KEEP_WIDTH-1:0] r_last_keep;

   logic                  w_cmd_ready;
   logic                  w_cmd_fire;
   logic                  w_beat_fire;
   logic [BEAT_W-1:0]     w_cmd_beats;
   logic [16:0]           w_cmd_rem;
   logic [KEEP_WIDTH-1:0] w_cmd_last_keep;
   logic [KEEP_WIDTH-1:0] w_cmd_first_keep;
   logic [DATA_WIDTH-1:0] w_cmd_first_data;
   logic                  w_next_last;
   logic [KEEP_WIDTH-1:0] w_next_keep;
   logic [DATA_WIDTH-1:0] w_next_data;

   // Lane k carries base+k; disabled lanes are zeroed.
   function automatic logic [DATA_WIDTH-1:0] f_beat(input logic [7:0] base,
                                                    input logic [KEEP_WIDTH-1:0] keep);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      for (int k = 0; k < KEEP_WIDTH; k++)
         d[8*k +: 8] = keep[k] ? (base + 8'(k)) : 8'h00;
      return d;
   endfunction

   assign w_cmd_ready = (r_state == ST_IDLE) && !rst;
   assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
   assign w_beat_fire = r_tvalid && bus.m_axis_tready;

   assign w_cmd_beats = BEAT_W'((17'(bus.cmd_len) + KEEP_M1) / KEEP_W17);
   assign w_cmd_rem   = 17'(bus.cmd_len) % KEEP_W17;

   always_comb begin
      w_cmd_last_keep = '0;
      for (int k = 0; k < KEEP_WIDTH; k++)
         w_cmd_last_keep[k] = (w_cmd_rem == 17'd0) || (17'(k) < w_cmd_rem);
   end

   assign w_cmd_first_keep = (w_cmd_beats == BEAT_W'(1)) ? w_cmd_last_keep : '1;
   assign w_cmd_first_data = f_beat(bus.cmd_seed, w_cmd_first_keep);

   assign w_next_last = (r_beats_left == BEAT_W'(1));
   assign w_next_keep = w_next_last ? r_last_keep : '1;
   assign w_next_data = f_beat(r_next_base, w_next_keep);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_tdata       <= '0;
         r_tkeep       <= '0;
         r_tvalid      <= 1'b0;
         r_tlast       <= 1'b0;
         r_tid         <= '0;
         r_tdest       <= '0;
         r_tuser       <= '0;
         r_err_len     <= 1'b0;
         r_frame_count <= '0;
         r_beats_left  <= '0;
         r_next_base   <= '0;
         r_last_keep   <= '0;
      end else begin
         r_err_len <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  if (bus.cmd_len == 16'd0) begin
                     r_err_len <= 1'b1;
                  end else begin
                     r_tid        <= bus.cmd_id;
                     r_tdest      <= bus.cmd_dest;
                     r_tuser      <= bus.cmd_user;
                     r_last_keep  <= w_cmd_last_keep;
                     r_tdata      <= w_cmd_first_data;
                     r_tkeep      <= w_cmd_first_keep;
                     r_tlast      <= (w_cmd_beats == BEAT_W'(1));
                     r_tvalid     <= 1'b1;
                     r_beats_left <= w_cmd_beats - BEAT_W'(1);
                     r_next_base  <= bus.cmd_seed + KEEP_STEP;
                     r_state      <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (w_beat_fire) begin
                  if (r_tlast) begin
                     r_tvalid      <= 1'b0;
                     r_tlast       <= 1'b0;
                     r_frame_count <= r_frame_count + 32'd1;
                     r_state       <= ST_IDLE;
                  end else begin
                     r_tdata      <= w_next_data;
                     r_tkeep      <= w_next_keep;
                     r_tlast      <= w_next_last;
                     r_beats_left <= r_beats_left - BEAT_W'(1);
                     r_next_base  <= r_next_base + KEEP_STEP;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready     = w_cmd_ready;
   assign bus.m_axis_tdata  = r_tdata;
   assign bus.m_axis_tkeep  = r_tkeep;
   assign bus.m_axis_tvalid = r_tvalid;
   assign bus.m_axis_tlast  = r_tlast;
   assign bus.m_axis_tid    = r_tid;
   assign bus.m_axis_tdest  = r_tdest;
   assign bus.m_axis_tuser  = r_tuser;

   assign busy        = (r_state == ST_SEND);
   assign err_len     = r_err_len;
   assign frame_count = r_frame_count;
endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source at DATA_WIDTH=32; inputs change and
// outputs are sampled on the falling edge.
module tb_axis_frame_source;
   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic        err_len;
   logic [31:0] frame_count;
   int          n_tests = 0;
   int          n_fail  = 0;

   axis_frame_source_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8),
                          .DEST_WIDTH(8), .USER_WIDTH(1)) bus ();

   axis_frame_source #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8),
                       .DEST_WIDTH(8), .USER_WIDTH(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .err_len     (err_len),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                       input logic l);
      chk({tag, ".tvalid"}, 64'(bus.m_axis_tvalid), 64'd1);
      chk({tag, ".tdata"},  64'(bus.m_axis_tdata),  64'(d));
      chk({tag, ".tkeep"},  64'(bus.m_axis_tkeep),  64'(k));
      chk({tag, ".tlast"},  64'(bus.m_axis_tlast),  64'(l));
   endtask

   task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed,
                           input logic [7:0] id, input logic [7:0] dest, input logic user);
      bus.cmd_len   = len;
      bus.cmd_seed  = seed;
      bus.cmd_id    = id;
      bus.cmd_dest  = dest;
      bus.cmd_user  = user;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_len = '0; bus.cmd_seed = '0; bus.cmd_id = '0; bus.cmd_dest = '0;
      bus.cmd_user = '0; bus.cmd_valid = 1'b0; bus.m_axis_tready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst.tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("rst.tdata",  64'(bus.m_axis_tdata),  64'd0);
      chk("rst.tkeep",  64'(bus.m_axis_tkeep),  64'd0);
      chk("rst.busy",   64'(busy),              64'd0);
      chk("rst.count",  64'(frame_count),       64'd0);
      chk("rst.cmd_ready_in_rst", 64'(bus.cmd_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst.cmd_ready_after", 64'(bus.cmd_ready), 64'd1);

      // basic 10-byte frame
      bus.m_axis_tready = 1'b1;
      @(negedge clk);
      send_cmd(16'd10, 8'hF0, 8'd3, 8'd5, 1'b1);
      beat("basic.b0", 32'hF3F2F1F0, 4'hF, 1'b0);
      chk("basic.tid",   64'(bus.m_axis_tid),   64'd3);
      chk("basic.tdest", 64'(bus.m_axis_tdest), 64'd5);
      chk("basic.tuser", 64'(bus.m_axis_tuser), 64'd1);
      chk("basic.busy",  64'(busy),             64'd1);
      chk("basic.cmd_ready", 64'(bus.cmd_ready), 64'd0);
      @(negedge clk);
      beat("basic.b1", 32'hF7F6F5F4, 4'hF, 1'b0);
      @(negedge clk);
      beat("basic.b2", 32'h0000F9F8, 4'h3, 1'b1);
      chk("basic.tid2", 64'(bus.m_axis_tid), 64'd3);
      @(negedge clk);
      chk("basic.end_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("basic.count",      64'(frame_count),       64'd1);
      chk("basic.idle_ready", 64'(bus.cmd_ready),     64'd1);

      // backpressure: tready 1,0,0,1,0,1
      bus.m_axis_tready = 1'b0;
      send_cmd(16'd8, 8'h00, 8'd1, 8'd2, 1'b0);
      beat("bp.b0", 32'h03020100, 4'hF, 1'b0);
      bus.m_axis_tready = 1'b1;
      @(negedge clk);
      beat("bp.b1", 32'h07060504, 4'hF, 1'b1);
      bus.m_axis_tready = 1'b0;
      @(negedge clk);
      beat("bp.hold1", 32'h07060504, 4'hF, 1'b1);
      @(negedge clk);
      beat("bp.hold2", 32'h07060504, 4'hF, 1'b1);
      chk("bp.hold_tid", 64'(bus.m_axis_tid), 64'd1);
      bus.m_axis_tready = 1'b1;
      @(negedge clk);
      chk("bp.end_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      bus.m_axis_tready = 1'b0;
      @(negedge clk);
      bus.m_axis_tready = 1'b1;
      chk("bp.count", 64'(frame_count), 64'd2);

      // boundary lengths
      send_cmd(16'd4, 8'h10, 8'd0, 8'd0, 1'b0);
      beat("len4", 32'h13121110, 4'hF, 1'b1);
      @(negedge clk);
      chk("len4.count", 64'(frame_count), 64'd3);
      send_cmd(16'd1, 8'hAB, 8'd0, 8'd0, 1'b0);
      beat("len1", 32'h000000AB, 4'h1, 1'b1);
      @(negedge clk);
      chk("len1.count", 64'(frame_count), 64'd4);
      send_cmd(16'd0, 8'h55, 8'd0, 8'd0, 1'b0);
      chk("len0.err",    64'(err_len),            64'd1);
      chk("len0.tvalid", 64'(bus.m_axis_tvalid),  64'd0);
      chk("len0.busy",   64'(busy),               64'd0);
      @(negedge clk);
      chk("len0.err_clr", 64'(err_len),     64'd0);
      chk("len0.count",   64'(frame_count), 64'd4);

      // back-to-back with cmd_valid held
      bus.cmd_len = 16'd4; bus.cmd_seed = 8'h20; bus.cmd_valid = 1'b1;
      @(negedge clk);
      beat("b2b.f1", 32'h23222120, 4'hF, 1'b1);
      chk("b2b.ready_busy", 64'(bus.cmd_ready), 64'd0);
      bus.cmd_seed = 8'h30;
      @(negedge clk);
      chk("b2b.gap_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("b2b.gap_ready",  64'(bus.cmd_ready),     64'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      beat("b2b.f2", 32'h33323130, 4'hF, 1'b1);
      @(negedge clk);
      chk("b2b.count", 64'(frame_count), 64'd6);

      // byte wrap and frame counter wrap
      force dut.r_frame_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_frame_count;
      chk("wrap.preset", 64'(frame_count), 64'hFFFF_FFFF);
      send_cmd(16'd4, 8'hFE, 8'd0, 8'd0, 1'b0);
      beat("wrap", 32'h0100FFFE, 4'hF, 1'b1);
      @(negedge clk);
      chk("wrap.count", 64'(frame_count), 64'd0);

      // reset during beat 2 of a 16-byte frame
      send_cmd(16'd16, 8'h40, 8'd9, 8'd9, 1'b1);
      beat("mid.b0", 32'h43424140, 4'hF, 1'b0);
      @(negedge clk);
      @(negedge clk);
      beat("mid.b2", 32'h4B4A4948, 4'hF, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid.tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("mid.tlast",  64'(bus.m_axis_tlast),  64'd0);
      chk("mid.tdata",  64'(bus.m_axis_tdata),  64'd0);
      chk("mid.tid",    64'(bus.m_axis_tid),    64'd0);
      chk("mid.tuser",  64'(bus.m_axis_tuser),  64'd0);
      chk("mid.busy",   64'(busy),              64'd0);
      chk("mid.count",  64'(frame_count),       64'd0);
      chk("mid.ready_in_rst", 64'(bus.cmd_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("mid.ready_after", 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      send_cmd(16'd4, 8'h55, 8'd7, 8'd8, 1'b0);
      beat("mid.new", 32'h58575655, 4'hF, 1'b1);
      chk("mid.new_tid", 64'(bus.m_axis_tid), 64'd7);
      @(negedge clk);
      chk("mid.new_count", 64'(frame_count), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
